// File: rtl/biriscv_mul_pkg.sv
// Shared definitions for the biRISC-V pipelined multiplier.
//   - RV32M/RV64M multiply instruction match/mask constants
//   - mul_sel_t: which slice of the full product is written back
//   - legal range of the issue-to-writeback latency
package biriscv_mul_pkg;

    localparam logic [31:0] INST_MUL         = 32'h0200_0033;
    localparam logic [31:0] INST_MUL_MASK    = 32'hfe00_707f;
    localparam logic [31:0] INST_MULH        = 32'h0200_1033;
    localparam logic [31:0] INST_MULH_MASK   = 32'hfe00_707f;
    localparam logic [31:0] INST_MULHSU      = 32'h0200_2033;
    localparam logic [31:0] INST_MULHSU_MASK = 32'hfe00_707f;
    localparam logic [31:0] INST_MULHU       = 32'h0200_3033;
    localparam logic [31:0] INST_MULHU_MASK  = 32'hfe00_707f;
    localparam logic [31:0] INST_MULW        = 32'h0200_003b;
    localparam logic [31:0] INST_MULW_MASK   = 32'hfe00_707f;

    localparam int STAGES_MIN = 2;
    localparam int STAGES_MAX = 4;

    typedef enum logic [1:0] {
        SEL_LO,
        SEL_HI,
        SEL_W
    } mul_sel_t;

    function automatic logic inst_match(input logic [31:0] inst,
                                        input logic [31:0] match,
                                        input logic [31:0] mask);
        return (inst & mask) == match;
    endfunction

endpackage

// File: rtl/biriscv_mul_delay.sv
// N-deep {valid, rd, value} delay chain used for the tail stages of the
// multiplier pipe. hold_i freezes every stage, flush_i clears every stage
// (flush wins). At DEPTH=0 the chain is plain wires.
//   clk_i, rst_ni      clock, async active-low reset
//   hold_i, flush_i    stall / kill
//   valid_i/rd_idx_i/value_i   stage input
//   valid_o/rd_idx_o/value_o   last stage output
//   busy_o             any stage of the chain holds a valid op
module biriscv_mul_delay #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             hold_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [4:0]       rd_idx_i,
    input  logic [WIDTH-1:0] value_i,
    output logic             valid_o,
    output logic [4:0]       rd_idx_o,
    output logic [WIDTH-1:0] value_o,
    output logic             busy_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = ^{clk_i, rst_ni, hold_i, flush_i};
            assign valid_o  = valid_i;
            assign rd_idx_o = rd_idx_i;
            assign value_o  = value_i;
            assign busy_o   = 1'b0;
        end else begin : g_chain
            logic             valid_q [DEPTH];
            logic             valid_d [DEPTH];
            logic [4:0]       rd_q    [DEPTH];
            logic [4:0]       rd_d    [DEPTH];
            logic [WIDTH-1:0] value_q [DEPTH];
            logic [WIDTH-1:0] value_d [DEPTH];

            always_comb begin
                for (int i = 0; i < DEPTH; i++) begin
                    valid_d[i] = valid_q[i];
                    rd_d[i]    = rd_q[i];
                    value_d[i] = value_q[i];
                end
                if (flush_i) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        valid_d[i] = 1'b0;
                        rd_d[i]    = '0;
                        value_d[i] = '0;
                    end
                end else if (!hold_i) begin
                    // Empty slots always carry zero tag and value.
                    valid_d[0] = valid_i;
                    rd_d[0]    = valid_i ? rd_idx_i : '0;
                    value_d[0] = valid_i ? value_i  : '0;
                    for (int i = 1; i < DEPTH; i++) begin
                        valid_d[i] = valid_q[i-1];
                        rd_d[i]    = rd_q[i-1];
                        value_d[i] = value_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        valid_q[i] <= 1'b0;
                        rd_q[i]    <= '0;
                        value_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        valid_q[i] <= valid_d[i];
                        rd_q[i]    <= rd_d[i];
                        value_q[i] <= value_d[i];
                    end
                end
            end

            always_comb begin
                busy_o = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    busy_o = busy_o | valid_q[i];
                end
            end

            assign valid_o  = valid_q[DEPTH-1];
            assign rd_idx_o = rd_q[DEPTH-1];
            assign value_o  = value_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/biriscv_mul_pipe.sv
// Fully pipelined integer multiplier for the biRISC-V execute pipe.
// E1 registers the extended operands, E2 registers the selected product,
// E3..E{STAGES} are pure delay stages. One op per cycle, latency STAGES.
//   clk_i, rst_ni                 clock, async active-low reset
//   opcode_valid_i/opcode_*_i     issue port (instruction, rd, rs1, rs2)
//   hold_i                        freeze every stage, refuse issue
//   flush_i                       kill in-flight and issuing ops
//   writeback_valid_o/rd_idx_o/value_o   result port
//   busy_o                        any stage holds a valid op
module biriscv_mul_pipe
    import biriscv_mul_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int STAGES       = 2,
    parameter bit SUPPORT_MULW = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            opcode_valid_i,
    input  logic [31:0]     opcode_opcode_i,
    input  logic [4:0]      opcode_rd_idx_i,
    input  logic [XLEN-1:0] opcode_ra_operand_i,
    input  logic [XLEN-1:0] opcode_rb_operand_i,
    input  logic            hold_i,
    input  logic            flush_i,
    output logic            writeback_valid_o,
    output logic [4:0]      writeback_rd_idx_o,
    output logic [XLEN-1:0] writeback_value_o,
    output logic            busy_o
);

    generate
        if (!((XLEN == 32) || (XLEN == 64))) begin : g_bad_xlen
            $error("biriscv_mul_pipe: XLEN must be 32 or 64");
        end
        if ((STAGES < STAGES_MIN) || (STAGES > STAGES_MAX)) begin : g_bad_stages
            $error("biriscv_mul_pipe: STAGES must be within 2..4");
        end
    endgenerate

    localparam int OPW     = XLEN + 1;
    localparam int PW      = 2 * OPW;
    localparam bit MULW_EN = (XLEN == 64) && SUPPORT_MULW;

    // Decode
    logic is_mul_lo, is_mulh, is_mulhsu, is_mulhu, is_mulw, is_mul, accept;

    assign is_mul_lo = inst_match(opcode_opcode_i, INST_MUL,    INST_MUL_MASK);
    assign is_mulh   = inst_match(opcode_opcode_i, INST_MULH,   INST_MULH_MASK);
    assign is_mulhsu = inst_match(opcode_opcode_i, INST_MULHSU, INST_MULHSU_MASK);
    assign is_mulhu  = inst_match(opcode_opcode_i, INST_MULHU,  INST_MULHU_MASK);
    assign is_mulw   = MULW_EN && inst_match(opcode_opcode_i, INST_MULW, INST_MULW_MASK);
    assign is_mul    = is_mul_lo | is_mulh | is_mulhsu | is_mulhu | is_mulw;
    assign accept    = opcode_valid_i & is_mul & ~hold_i & ~flush_i;

    // Operand extension to XLEN+1 so one signed multiplier covers all forms
    logic [OPW-1:0] a_ext, b_ext;
    mul_sel_t       sel_ext;

    always_comb begin
        a_ext   = {1'b0, opcode_ra_operand_i};
        b_ext   = {1'b0, opcode_rb_operand_i};
        sel_ext = SEL_LO;
        if (is_mulh) begin
            a_ext   = {opcode_ra_operand_i[XLEN-1], opcode_ra_operand_i};
            b_ext   = {opcode_rb_operand_i[XLEN-1], opcode_rb_operand_i};
            sel_ext = SEL_HI;
        end else if (is_mulhsu) begin
            a_ext   = {opcode_ra_operand_i[XLEN-1], opcode_ra_operand_i};
            sel_ext = SEL_HI;
        end else if (is_mulhu) begin
            sel_ext = SEL_HI;
        end else if (is_mulw) begin
            a_ext        = {OPW{opcode_ra_operand_i[31]}};
            a_ext[31:0]  = opcode_ra_operand_i[31:0];
            b_ext        = {OPW{opcode_rb_operand_i[31]}};
            b_ext[31:0]  = opcode_rb_operand_i[31:0];
            sel_ext      = SEL_W;
        end
    end

    // E1
    logic           valid_e1_q, valid_e1_d;
    logic [4:0]     rd_e1_q, rd_e1_d;
    logic [OPW-1:0] a_e1_q, a_e1_d, b_e1_q, b_e1_d;
    mul_sel_t       sel_e1_q, sel_e1_d;

    always_comb begin
        valid_e1_d = valid_e1_q;
        rd_e1_d    = rd_e1_q;
        a_e1_d     = a_e1_q;
        b_e1_d     = b_e1_q;
        sel_e1_d   = sel_e1_q;
        if (flush_i || !hold_i) begin
            // accept already folds in hold/flush; a refused slot is all zero
            valid_e1_d = accept;
            rd_e1_d    = accept ? opcode_rd_idx_i : '0;
            a_e1_d     = accept ? a_ext : '0;
            b_e1_d     = accept ? b_ext : '0;
            sel_e1_d   = accept ? sel_ext : SEL_LO;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_e1_q <= 1'b0;
            rd_e1_q    <= '0;
            a_e1_q     <= '0;
            b_e1_q     <= '0;
            sel_e1_q   <= SEL_LO;
        end else begin
            valid_e1_q <= valid_e1_d;
            rd_e1_q    <= rd_e1_d;
            a_e1_q     <= a_e1_d;
            b_e1_q     <= b_e1_d;
            sel_e1_q   <= sel_e1_d;
        end
    end

    // Product and result select
    logic signed [PW-1:0] a_full, b_full, product;
    logic [XLEN-1:0]      w_ext, result;
    logic [1:0]           unused_prod_hi;

    assign a_full         = {{OPW{a_e1_q[OPW-1]}}, a_e1_q};
    assign b_full         = {{OPW{b_e1_q[OPW-1]}}, b_e1_q};
    assign product        = a_full * b_full;
    assign unused_prod_hi = product[PW-1 -: 2];

    always_comb begin
        w_ext       = {XLEN{product[31]}};
        w_ext[31:0] = product[31:0];
        case (sel_e1_q)
            SEL_HI:  result = product[2*XLEN-1:XLEN];
            SEL_W:   result = w_ext;
            default: result = product[XLEN-1:0];
        endcase
    end

    // E2
    logic            valid_e2_q, valid_e2_d;
    logic [4:0]      rd_e2_q, rd_e2_d;
    logic [XLEN-1:0] value_e2_q, value_e2_d;

    always_comb begin
        valid_e2_d = valid_e2_q;
        rd_e2_d    = rd_e2_q;
        value_e2_d = value_e2_q;
        if (flush_i) begin
            valid_e2_d = 1'b0;
            rd_e2_d    = '0;
            value_e2_d = '0;
        end else if (!hold_i) begin
            valid_e2_d = valid_e1_q;
            rd_e2_d    = rd_e1_q;
            value_e2_d = valid_e1_q ? result : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_e2_q <= 1'b0;
            rd_e2_q    <= '0;
            value_e2_q <= '0;
        end else begin
            valid_e2_q <= valid_e2_d;
            rd_e2_q    <= rd_e2_d;
            value_e2_q <= value_e2_d;
        end
    end

    // E3..E{STAGES}
    logic tail_busy;

    biriscv_mul_delay #(
        .DEPTH (STAGES - 2),
        .WIDTH (XLEN)
    ) u_delay (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .hold_i   (hold_i),
        .flush_i  (flush_i),
        .valid_i  (valid_e2_q),
        .rd_idx_i (rd_e2_q),
        .value_i  (value_e2_q),
        .valid_o  (writeback_valid_o),
        .rd_idx_o (writeback_rd_idx_o),
        .value_o  (writeback_value_o),
        .busy_o   (tail_busy)
    );

    assign busy_o = valid_e1_q | valid_e2_q | tail_busy;

endmodule

// File: tb/tb_biriscv_mul_pipe.sv
// Directed bench: four multiplier instances (32-bit at 2/3/4 stages and a
// 64-bit MULW-capable 2-stage) share one issue port.
module tb_biriscv_mul_pipe;

    localparam logic [31:0] OP_MUL    = 32'h0200_0033;
    localparam logic [31:0] OP_MULH   = 32'h0200_1033;
    localparam logic [31:0] OP_MULHSU = 32'h0200_2033;
    localparam logic [31:0] OP_MULHU  = 32'h0200_3033;
    localparam logic [31:0] OP_MULW   = 32'h0200_003b;
    localparam logic [31:0] OP_ADD    = 32'h0000_0033;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid;
    logic [31:0] opcode;
    logic [4:0]  rd;
    logic [63:0] ra, rb;
    logic        hold, flush;

    logic        v_s2, v_s3, v_s4, v_w;
    logic [4:0]  rd_s2, rd_s3, rd_s4, rd_w;
    logic [31:0] val_s2, val_s3, val_s4;
    logic [63:0] val_w;
    logic        busy_s2, busy_s3, busy_s4, busy_w;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    biriscv_mul_pipe #(.XLEN(32), .STAGES(2), .SUPPORT_MULW(1'b0)) u_s2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .opcode_valid_i(valid), .opcode_opcode_i(opcode),
        .opcode_rd_idx_i(rd), .opcode_ra_operand_i(ra[31:0]), .opcode_rb_operand_i(rb[31:0]),
        .hold_i(hold), .flush_i(flush), .writeback_valid_o(v_s2), .writeback_rd_idx_o(rd_s2),
        .writeback_value_o(val_s2), .busy_o(busy_s2));

    biriscv_mul_pipe #(.XLEN(32), .STAGES(3), .SUPPORT_MULW(1'b0)) u_s3 (
        .clk_i(clk_i), .rst_ni(rst_ni), .opcode_valid_i(valid), .opcode_opcode_i(opcode),
        .opcode_rd_idx_i(rd), .opcode_ra_operand_i(ra[31:0]), .opcode_rb_operand_i(rb[31:0]),
        .hold_i(hold), .flush_i(flush), .writeback_valid_o(v_s3), .writeback_rd_idx_o(rd_s3),
        .writeback_value_o(val_s3), .busy_o(busy_s3));

    biriscv_mul_pipe #(.XLEN(32), .STAGES(4), .SUPPORT_MULW(1'b0)) u_s4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .opcode_valid_i(valid), .opcode_opcode_i(opcode),
        .opcode_rd_idx_i(rd), .opcode_ra_operand_i(ra[31:0]), .opcode_rb_operand_i(rb[31:0]),
        .hold_i(hold), .flush_i(flush), .writeback_valid_o(v_s4), .writeback_rd_idx_o(rd_s4),
        .writeback_value_o(val_s4), .busy_o(busy_s4));

    biriscv_mul_pipe #(.XLEN(64), .STAGES(2), .SUPPORT_MULW(1'b1)) u_w (
        .clk_i(clk_i), .rst_ni(rst_ni), .opcode_valid_i(valid), .opcode_opcode_i(opcode),
        .opcode_rd_idx_i(rd), .opcode_ra_operand_i(ra), .opcode_rb_operand_i(rb),
        .hold_i(hold), .flush_i(flush), .writeback_valid_o(v_w), .writeback_rd_idx_o(rd_w),
        .writeback_value_o(val_w), .busy_o(busy_w));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [31:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] r);
        valid  = 1'b1;
        opcode = op;
        ra     = a;
        rb     = b;
        rd     = r;
    endtask

    task automatic idle();
        valid  = 1'b0;
        opcode = '0;
        ra     = '0;
        rb     = '0;
        rd     = '0;
    endtask

    // Single op through the two 2-stage instances.
    task automatic op_check(input string tag, input logic [31:0] op, input logic [63:0] a,
                            input logic [63:0] b, input logic [4:0] r,
                            input logic v32, input logic [31:0] e32, input logic [63:0] e64);
        issue(op, a, b, r);
        tick();
        idle();
        tick();
        check({tag, "_v32"},   64'(v_s2),   64'(v32));
        check({tag, "_val32"}, 64'(val_s2), 64'(e32));
        check({tag, "_v64"},   64'(v_w),    64'(1'b1));
        check({tag, "_rd64"},  64'(rd_w),   64'(r));
        check({tag, "_val64"}, val_w,       e64);
        tick();
    endtask

    initial begin
        rst_ni = 1'b0;
        hold   = 1'b0;
        flush  = 1'b0;
        idle();
        tick();
        tick();
        check("rst_v_s2",    64'(v_s2),    64'd0);
        check("rst_val_s2",  64'(val_s2),  64'd0);
        check("rst_rd_s2",   64'(rd_s2),   64'd0);
        check("rst_busy_s4", 64'(busy_s4), 64'd0);
        check("rst_val_w",   val_w,        64'd0);
        check("rst_busy_w",  64'(busy_w),  64'd0);
        rst_ni = 1'b1;
        tick();

        // MUL 7*6 latency
        issue(OP_MUL, 64'd7, 64'd6, 5'd5);
        tick();
        idle();
        check("t1_v_early",   64'(v_s2),    64'd0);
        check("t1_busy",      64'(busy_s2), 64'd1);
        tick();
        check("t1_v",         64'(v_s2),    64'd1);
        check("t1_val",       64'(val_s2),  64'h2a);
        check("t1_rd",        64'(rd_s2),   64'd5);
        tick();
        check("t1_v_late",    64'(v_s2),    64'd0);
        check("t1_val_late",  64'(val_s2),  64'd0);
        check("t1_rd_late",   64'(rd_s2),   64'd0);
        check("t1_busy_late", 64'(busy_s2), 64'd0);
        check("t1_s3_v",      64'(v_s3),    64'd1);
        check("t1_s3_val",    64'(val_s3),  64'h2a);
        tick();
        check("t1_s4_val",    64'(val_s4),  64'h2a);
        check("t1_s4_rd",     64'(rd_s4),   64'd5);
        tick();
        tick();

        // High-half variants, MULW, wide MUL
        op_check("mulh",   OP_MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1,
                 1'b1, 32'h0000_0000, 64'h0);
        op_check("mulhu",  OP_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2,
                 1'b1, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE);
        op_check("mulhsu", OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3,
                 1'b1, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        op_check("mulw0",  OP_MULW,   64'h0000_0000_8000_0000, 64'd2, 5'd4,
                 1'b0, 32'h0, 64'h0);
        op_check("mulw1",  OP_MULW,   64'h0000_0000_4000_0000, 64'd2, 5'd6,
                 1'b0, 32'h0, 64'hFFFF_FFFF_8000_0000);
        op_check("mul64",  OP_MUL,    64'h0000_0001_0000_0003, 64'h10, 5'd7,
                 1'b1, 32'h30, 64'h0000_0010_0000_0030);

        // Non-mul opcode is ignored everywhere
        issue(OP_ADD, 64'd3, 64'd4, 5'd9);
        tick();
        idle();
        check("add_busy_w",  64'(busy_w),  64'd0);
        tick();
        check("add_v_s2",    64'(v_s2),    64'd0);
        check("add_v_w",     64'(v_w),     64'd0);
        tick();
        tick();

        // STAGES=3 back-to-back with a 2-cycle hold
        issue(OP_MUL, 64'd2, 64'd3, 5'd1);
        tick();
        issue(OP_MUL, 64'd4, 64'd5, 5'd2);
        tick();
        issue(OP_MUL, 64'd6, 64'd7, 5'd3);
        tick();
        idle();
        check("hold_a_v",     64'(v_s3),   64'd1);
        check("hold_a_val",   64'(val_s3), 64'd6);
        hold = 1'b1;
        tick();
        check("hold_a_val1",  64'(val_s3), 64'd6);
        check("hold_a_rd1",   64'(rd_s3),  64'd1);
        tick();
        hold = 1'b0;
        check("hold_a_val2",  64'(val_s3), 64'd6);
        check("hold_a_v2",    64'(v_s3),   64'd1);
        tick();
        check("hold_b_val",   64'(val_s3), 64'd20);
        check("hold_b_rd",    64'(rd_s3),  64'd2);
        tick();
        check("hold_c_val",   64'(val_s3), 64'd42);
        check("hold_c_rd",    64'(rd_s3),  64'd3);
        tick();
        check("hold_end_v",   64'(v_s3),    64'd0);
        check("hold_end_busy",64'(busy_s3), 64'd0);
        tick();
        tick();

        // STAGES=4 flush with three ops in flight plus one issuing
        issue(OP_MUL, 64'd1, 64'd1, 5'd1);
        tick();
        issue(OP_MUL, 64'd2, 64'd2, 5'd2);
        tick();
        issue(OP_MUL, 64'd3, 64'd3, 5'd3);
        tick();
        check("flush_pre_busy", 64'(busy_s4), 64'd1);
        check("flush_pre_v",    64'(v_s4),    64'd0);
        issue(OP_MUL, 64'd4, 64'd4, 5'd4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        check("flush_busy", 64'(busy_s4), 64'd0);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("flush_v_%0d", i), 64'(v_s4), 64'd0);
            tick();
        end
        check("flush_busy_end", 64'(busy_s4), 64'd0);

        // Asynchronous reset with ops in flight
        issue(OP_MUL, 64'd5, 64'd5, 5'd4);
        tick();
        issue(OP_MUL, 64'd2, 64'd2, 5'd6);
        tick();
        idle();
        check("rst_pre_v",   64'(v_s2),   64'd1);
        check("rst_pre_val", 64'(val_s2), 64'd25);
        #3;
        rst_ni = 1'b0;
        #1;
        check("arst_v_s2",    64'(v_s2),    64'd0);
        check("arst_val_s2",  64'(val_s2),  64'd0);
        check("arst_rd_s2",   64'(rd_s2),   64'd0);
        check("arst_busy_s2", 64'(busy_s2), 64'd0);
        check("arst_busy_s4", 64'(busy_s4), 64'd0);
        #2;
        rst_ni = 1'b1;
        tick();
        issue(OP_MUL, 64'd3, 64'd3, 5'd7);
        tick();
        idle();
        tick();
        check("post_s2_v",   64'(v_s2),   64'd1);
        check("post_s2_val", 64'(val_s2), 64'd9);
        check("post_s2_rd",  64'(rd_s2),  64'd7);
        tick();
        check("post_s4_early", 64'(v_s4), 64'd0);
        tick();
        check("post_s4_v",   64'(v_s4),   64'd1);
        check("post_s4_val", 64'(val_s4), 64'd9);
        check("post_s4_rd",  64'(rd_s4),  64'd7);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
